// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares one scoreboard writeback port between several
// functional-unit result producers. Each requester owns a one-entry holding
// register; a round-robin pointer picks one full entry per cycle and forwards
// it through a registered writeback stage. A flush drops everything in flight.
module wb_port_arbiter #(
    parameter int NR_REQ        = 3,
    parameter int TRANS_ID_BITS = 3,
    parameter int XLEN          = 64,
    parameter int IDX_W         = $clog2(NR_REQ)
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 flush_i,
    input  logic [NR_REQ-1:0]                    req_valid_i,
    output logic [NR_REQ-1:0]                    req_ready_o,
    input  logic [NR_REQ-1:0][TRANS_ID_BITS-1:0] req_trans_id_i,
    input  logic [NR_REQ-1:0][XLEN-1:0]          req_data_i,
    input  logic [NR_REQ-1:0]                    req_ex_valid_i,
    output logic                                 wb_valid_o,
    output logic [TRANS_ID_BITS-1:0]             wb_trans_id_o,
    output logic [XLEN-1:0]                      wb_data_o,
    output logic                                 wb_ex_valid_o,
    output logic [IDX_W-1:0]                     grant_idx_o,
    output logic                                 conflict_o,
    output logic                                 busy_o
);

    // Holding registers: control bit is reset, payload is not
    logic [NR_REQ-1:0]                    hold_full;
    logic [NR_REQ-1:0][TRANS_ID_BITS-1:0] hold_id;
    logic [NR_REQ-1:0][XLEN-1:0]          hold_data;
    logic [NR_REQ-1:0]                    hold_ex;

    logic [IDX_W-1:0]         rr_ptr;
    logic [IDX_W-1:0]         rr_next;
    logic [IDX_W-1:0]         win_idx;
    logic [NR_REQ-1:0]        grant;
    logic [NR_REQ-1:0]        load;
    logic                     any_grant;
    logic                     multi_full;
    logic [TRANS_ID_BITS-1:0] win_id;
    logic [XLEN-1:0]          win_data;
    logic                     win_ex;

    // Round-robin pick: first full entry scanning upward from rr_ptr (mod NR_REQ).
    // Depends only on registered state, so ready never loops back through valid.
    always_comb begin
        grant     = '0;
        win_idx   = '0;
        any_grant = 1'b0;
        for (int k = 0; k < NR_REQ; k++) begin
            for (int i = 0; i < NR_REQ; i++) begin
                if (!any_grant && hold_full[i] && (((int'(rr_ptr) + k) % NR_REQ) == i)) begin
                    any_grant = 1'b1;
                    grant[i]  = 1'b1;
                    win_idx   = IDX_W'(i);
                end
            end
        end
    end

    assign win_id   = hold_id[win_idx];
    assign win_data = hold_data[win_idx];
    assign win_ex   = hold_ex[win_idx];

    assign rr_next = (win_idx == IDX_W'(NR_REQ - 1)) ? '0 : win_idx + 1'b1;

    // A granted entry drains this cycle, so it may be refilled in the same cycle
    assign req_ready_o = ~hold_full | grant;
    assign load        = req_valid_i & req_ready_o;

    assign multi_full = ($countones(hold_full) >= 2);
    assign busy_o     = (|hold_full) | wb_valid_o;

    // Control state: occupancy, pointer, writeback valid, grant index, conflict pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_full   <= '0;
            rr_ptr      <= '0;
            wb_valid_o  <= 1'b0;
            grant_idx_o <= '0;
            conflict_o  <= 1'b0;
        end else begin
            conflict_o <= multi_full;
            if (flush_i) begin
                hold_full  <= '0;
                rr_ptr     <= '0;
                wb_valid_o <= 1'b0;
            end else begin
                hold_full  <= (hold_full & ~grant) | load;
                wb_valid_o <= any_grant;
                if (any_grant) begin
                    grant_idx_o <= win_idx;
                    rr_ptr      <= rr_next;
                end
            end
        end
    end

    // Writeback payload: loads the winner's fields, holds when nothing is granted
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_trans_id_o <= '0;
            wb_data_o     <= '0;
            wb_ex_valid_o <= 1'b0;
        end else if (any_grant && !flush_i) begin
            wb_trans_id_o <= win_id;
            wb_data_o     <= win_data;
            wb_ex_valid_o <= win_ex;
        end
    end

    // Holding payload capture on each accepted handshake
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NR_REQ; i++) begin
            if (load[i]) begin
                hold_id[i]   <= req_trans_id_i[i];
                hold_data[i] <= req_data_i[i];
                hold_ex[i]   <= req_ex_valid_i[i];
            end
        end
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Round-robin arbiter that shares one scoreboard writeback port between several functional-unit result producers, e.g. the multiplier, the CSR buffer and a CVXIF result path. Each requester gets a one-entry holding register. One winner per cycle is forwarded through a registered output stage to the scoreboard `trans_id`/`wbdata`/`ex`/`wt_valid` inputs of the issue stage. The block sits between the execute-stage units and the issue stage, and drops all in-flight results on a pipeline flush.

## Interface
Parameters:
- `NR_REQ`, 3: number of requesters, ≥2.
- `TRANS_ID_BITS`, 3: scoreboard transaction-id width.
- `XLEN`, 64: result data width.
- `IDX_W`, `$clog2(NR_REQ)`: grant index width (derived).

Ports:
- `clk_i` in 1: clock. One clock domain; all state changes on the rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: discard all held and outgoing results.
- `req_valid_i` in NR_REQ: requester result valid.
- `req_ready_o` out NR_REQ: holding register can accept.
- `req_trans_id_i` in NR_REQ×TRANS_ID_BITS: scoreboard id per requester.
- `req_data_i` in NR_REQ×XLEN: result data per requester.
- `req_ex_valid_i` in NR_REQ: result carries an exception.
- `wb_valid_o` out 1: writeback valid (registered).
- `wb_trans_id_o` out TRANS_ID_BITS: writeback id (registered).
- `wb_data_o` out XLEN: writeback data (registered).
- `wb_ex_valid_o` out 1: writeback exception flag (registered).
- `grant_idx_o` out IDX_W: index of the requester driving the current `wb_*` (registered).
- `conflict_o` out 1: pulse, two or more holding registers were full in the previous cycle (performance counter).
- `busy_o` out 1: any holding register full, or `wb_valid_o` high.

## Operation
Holding registers:
- Per requester: `hold_full[i]`, id, data, ex.
- Load: on `req_valid_i[i] & req_ready_o[i]`, the register loads and `hold_full[i]` is set.

Grant:
- `grant[i]` is combinational from `hold_full` and `rr_ptr` only.
- It is one-hot: the first `i` with `hold_full[i]`, scanning from `rr_ptr` upward modulo NR_REQ.
- `grant` has no path from `req_valid_i`, so there is no combinational loop.

Ready:
- `req_ready_o[i] = ~hold_full[i] | grant[i]`.
- A granted entry can be refilled in the same cycle, giving 1 result per cycle per requester.

Output stage, each cycle:
- If any grant: `wb_*` registers load the winner's fields, `wb_valid_o`←1, `grant_idx_o`←winner, and the winner's `hold_full` clears unless it is refilled that cycle.
- If no grant: `wb_valid_o`←0; the other `wb_*` fields hold their values.

`rr_ptr` (IDX_W bits):
- After a grant of `g`, it becomes `g+1`, wrapping NR_REQ-1→0.
- Unchanged when there is no grant.

The output is never back-pressured: the scoreboard always accepts a writeback.

`conflict_o` ← (popcount(`hold_full`) ≥ 2), registered.

Flush (`flush_i`=1 at a clock edge):
- All `hold_full`←0, `wb_valid_o`←0, `rr_ptr`←0.
- Handshakes completing in the flush cycle are discarded.
- `wb_*` data fields are don't-care.

Flush takes priority over the same-cycle grant and load.

## Timing
Reset values (asserted asynchronously, held while `rst_i`=1):
- Zero: `wb_valid_o`, `wb_trans_id_o`, `wb_data_o`, `wb_ex_valid_o`, `grant_idx_o`, `conflict_o`, `busy_o`, `rr_ptr`, all `hold_full`.
- `req_ready_o` = all ones.

Latency:
- Handshake at edge N; entry is full during cycle N..N+1.
- If granted in that cycle, `wb_valid_o`=1 after edge N+1, for exactly one cycle per result.
- Minimum latency is 1 cycle from handshake to `wb_valid_o`.
- Worst-case wait for a held entry is NR_REQ-1 extra cycles; no starvation.

Throughput: one writeback per cycle aggregate.

Boundary conditions:
- Simultaneous grant and refill of the same requester: the new entry is stored and the old one is output.
- All requesters full: each is served in rotation, with no bubbles.
- `rst_i` mid-operation: all state returns to reset values immediately, and held results are lost.
- `req_valid_i` while `req_ready_o`=0: ignored; the requester must hold its fields stable until ready.

## Test plan
- Reset, then `req_valid_i`=001 with id 5, data 0xAB for one cycle.
  - Next cycle: `wb_valid_o`=1, `wb_trans_id_o`=5, `wb_data_o`=0xAB, `grant_idx_o`=0.
  - Following cycle: `wb_valid_o`=0.
- All 3 requesters valid in the same cycle (ids 1, 2, 3), `rr_ptr`=0.
  - `wb_trans_id_o` sequence is 1, 2, 3 on consecutive cycles.
  - `conflict_o`=1 for 2 cycles.
  - `rr_ptr` wraps to 0.
- Requester 2 streams 8 back-to-back results with others idle.
  - `req_ready_o[2]` stays 1.
  - 8 consecutive `wb_valid_o` cycles with ids in order.
- Requesters 0 and 1 full, `flush_i`=1 for one cycle with a new handshake on requester 2.
  - Next cycle: `wb_valid_o`=0, `busy_o`=0.
  - Requester 2's result is never written back.
- Assert `rst_i` asynchronously mid-stream.
  - All outputs take reset values before the next edge.
  - After deassertion, a single request completes with latency 1.
- Requester 2 granted (`rr_ptr`→0), then requesters 0 and 2 both full.
  - Requester 0 is served first, then 2.
